// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder_pkg
//  Purpose  : Shared constants and elaboration helpers for pipelined_adder.
//  Revision : 1.0 - initial release
// ============================================================================
package pipelined_adder_pkg;

    // Operation select encoding for op_sub.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Bits handled per pipeline stage; 0 flags an illegal configuration.
    function automatic int chunk_width(input int width, input int stages);
        if (width < 2 || stages < 1 || (width % stages) != 0) begin
            return 0;
        end
        return width / stages;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder_if
//  Purpose  : Operand/result handshake bundle for pipelined_adder.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipelined_adder_if #(
    parameter int WIDTH = 16
) ();
    import pipelined_adder_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, cin, op_sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, op_sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder_slice.sv
`default_nettype none
// ============================================================================
//  Module   : adder_slice
//  Purpose  : Combinational CHUNK-bit adder with carry into its top bit.
//  Revision : 1.0 - initial release
// ============================================================================
module adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_o
);
    logic [CHUNK:0] total;

    assign total  = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
    assign sum_o  = total[CHUNK-1:0];
    assign cout_o = total[CHUNK];
    // Carry into the top bit is recovered from the top sum bit and its operands.
    assign c_msb_o = total[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder
//  Purpose  : WIDTH-bit add/subtract unit pipelined over STAGES carry chunks
//             with valid/ready handshakes and a global stall.
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);
    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (CHUNK == 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
    end

    // Per-stage inputs (what stage k sees this cycle) and next-state values.
    logic             st_v    [STAGES];
    logic             st_c    [STAGES];
    logic [WIDTH-1:0] st_a    [STAGES];
    logic [WIDTH-1:0] st_b    [STAGES];
    logic [WIDTH-1:0] st_sum  [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             carry_d [STAGES];
    logic             cmsb    [STAGES];
    logic             ovf_d;

    // Per-stage pipeline registers.
    logic             valid_q [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             ovf_q;

    logic             stall;

    // The whole pipe freezes while the consumer refuses a valid result.
    assign stall        = valid_q[STAGES-1] & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = sum_q[STAGES-1];
    assign bus.cout      = carry_q[STAGES-1];
    assign bus.ovf       = ovf_q;

    assign ovf_d = cmsb[STAGES-1] ^ carry_d[STAGES-1];

    // Skew registers: operand bits still waiting for their stage, shifted down
    // so every stage always adds the low CHUNK bits of what it receives.
    if (STAGES > 1) begin : g_skew
        logic [WIDTH-1:0] a_q [STAGES-1];
        logic [WIDTH-1:0] b_q [STAGES-1];

        // Advance unconsumed operand chunks alongside each valid beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < STAGES - 1; k++) begin
                    a_q[k] <= '0;
                    b_q[k] <= '0;
                end
            end else if (!stall) begin
                for (int k = 0; k < STAGES - 1; k++) begin
                    if (st_v[k]) begin
                        a_q[k] <= st_a[k] >> CHUNK;
                        b_q[k] <= st_b[k] >> CHUNK;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] slice_sum;
        logic [WIDTH-1:0] sum_next;

        if (k == 0) begin : g_first
            // Subtraction is a + ~b + 1; cin only matters for addition.
            assign st_v[k]   = bus.in_valid & ~stall;
            assign st_a[k]   = bus.a;
            assign st_b[k]   = (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
            assign st_c[k]   = (bus.op_sub == OP_SUB) ? 1'b1 : bus.cin;
            assign st_sum[k] = '0;
        end else begin : g_next
            assign st_v[k]   = valid_q[k-1];
            assign st_a[k]   = g_skew.a_q[k-1];
            assign st_b[k]   = g_skew.b_q[k-1];
            assign st_c[k]   = carry_q[k-1];
            assign st_sum[k] = sum_q[k-1];
        end

        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a_i     (st_a[k][CHUNK-1:0]),
            .b_i     (st_b[k][CHUNK-1:0]),
            .cin_i   (st_c[k]),
            .sum_o   (slice_sum),
            .cout_o  (carry_d[k]),
            .c_msb_o (cmsb[k])
        );

        // Drop this stage's chunk into the partial result carried forward.
        always_comb begin
            sum_next                     = st_sum[k];
            sum_next[k*CHUNK +: CHUNK]   = slice_sum;
        end

        assign sum_d[k] = sum_next;
    end

    // Stage registers: valid bits always shift unless stalled; data only
    // loads on a valid beat so an idle output keeps its last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                sum_q[k]   <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= st_v[k];
                if (st_v[k]) begin
                    carry_q[k] <= carry_d[k];
                    sum_q[k]   <= sum_d[k];
                end
            end
            if (st_v[STAGES-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end
endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised N-bit add/subtract unit, pipelined over STAGES carry-chunk stages, with valid/ready handshakes on input and output.
- Successor to the fixed 4-bit ripple adders: width and pipeline depth are generalised, and it adds a subtract mode, a signed overflow flag and backpressure.
- Sits between operand producers and any datapath consumer that needs a registered, high-Fmax adder.

Parameters:
- WIDTH, 16, operand and result width in bits; must be >= 2.
- STAGES, 4, number of pipeline stages. WIDTH % STAGES == 0 is required; violating configurations fail elaboration.
- CHUNK, WIDTH/STAGES, derived localparam: bits added per stage.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when op_sub=0.
- op_sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1, with cin ignored.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  output  1  signed two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - all stage valid bits 0; all data, carry and skew registers 0.
  - out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- Stall rule:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, a combinational function of registered out_valid and out_ready.
  - While stall=1, every pipeline register holds, including bubbles; no beat is dropped or duplicated.
- Accept: a beat is accepted on a rising edge with in_valid & in_ready.
- Latency and throughput:
  - Latency is exactly STAGES cycles from acceptance to out_valid=1, with no stalls.
  - Throughput is one beat per cycle.
  - Bubbles propagate as valid=0 and are not squeezed out.
- Stage k (0..STAGES-1) operation:
  - Adds chunk k of A and of B_eff (B_eff = op_sub ? ~b : b) plus the carry registered by stage k-1.
  - Stage 0 uses cin_eff = op_sub ? 1 : cin.
  - Stage k registers: its CHUNK sum bits, its carry-out, and the not-yet-consumed upper chunks of A and B_eff (skew registers).
  - Lower sum chunks are carried forward alongside.
- Final stage:
  - cout = carry out of the MSB.
  - ovf = carry into the MSB XOR cout.
  - Both are registered together with sum and appear in the same cycle as out_valid.
- Output hold: sum, cout and ovf hold their values while out_valid=1 and out_ready=0.
- Output when idle: while out_valid=0, sum, cout and ovf are don't-care for consumers. The implementation holds the last registered value.
- Wrap-around: results are modulo 2^WIDTH; there is no saturation. Carry and overflow are reported only through cout and ovf.
- STAGES=1: degenerates to a single registered WIDTH-bit adder with latency 1.
- Simultaneous events: in_valid while out_ready transitions from 0 to 1 is accepted in that same cycle, because in_ready follows stall combinationally.
- Reset mid-operation: all in-flight beats are discarded. out_valid is 0 from the assertion of rst_n=0 onward.

Decomposition:
- Package pipelined_adder_pkg holds:
  - a function computing CHUNK with an elaboration-time legality check;
  - an op-mode constant pair OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module adder_slice: combinational, parametrised by CHUNK.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_msb (the carry into its top bit, used for ovf).
  - Instantiated once per stage in a generate loop.
- Pipeline registers, skew registers and handshake logic live in pipelined_adder.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- Carry chain: a=0xFFFF, b=0x0001, cin=0, add, out_ready=1 -> after 4 cycles sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1. Also a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
- Subtract mode:
  - a=0x0005, b=0x0007, op_sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, op_sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Backpressure: stream 6 back-to-back beats (a=i, b=0x0100·i), hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, all 6 results in order with no loss or duplication, sum=0x0101·i.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid=0, sum=0, in_ready=1 immediately. After release, a new beat (a=2, b=3) yields sum=0x0005 exactly 4 cycles after acceptance.
- STAGES=1 and STAGES=16 builds: random 1000-beat stream with random in_valid/out_ready checked against a+b+cin (mod 2^16) scoreboard. Latency is 1 and 16 respectively.
